// File: rtl/hack_boot_system.sv
// Hack computer top level with a streamed, writable instruction RAM and a
// run controller that loads a program, runs the CPU and detects completion or timeout.

module HackCpu (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [15:0] pc
);
    logic [15:0] regA;
    logic [15:0] regD;
    logic [15:0] yOperand;
    logic [15:0] xZero;
    logic [15:0] xNeg;
    logic [15:0] yZero;
    logic [15:0] yNeg;
    logic [15:0] aluSum;
    logic [15:0] aluOut;
    logic        isC;
    logic        zr;
    logic        ng;
    logic        jump;
    logic        unusedCodeBits;

    assign isC            = instruction[15];
    assign unusedCodeBits = ^instruction[14:13];

    // Hack ALU: control bits zx nx zy ny f no sit in instruction[11:6]
    always_comb begin
        yOperand = instruction[12] ? inM : regA;
        xZero    = instruction[11] ? 16'h0000 : regD;
        xNeg     = instruction[10] ? ~xZero : xZero;
        yZero    = instruction[9] ? 16'h0000 : yOperand;
        yNeg     = instruction[8] ? ~yZero : yZero;
        aluSum   = instruction[7] ? (xNeg + yNeg) : (xNeg & yNeg);
        aluOut   = instruction[6] ? ~aluSum : aluSum;
    end

    assign zr   = (aluOut == 16'h0000);
    assign ng   = aluOut[15];
    assign jump = isC & ((instruction[2] & ng) | (instruction[1] & zr) |
                         (instruction[0] & ~ng & ~zr));

    // While held, the PC parks at 0 and no register or memory state changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA <= 16'h0000;
            regD <= 16'h0000;
            pc   <= 16'h0000;
        end else if (hold) begin
            pc <= 16'h0000;
        end else begin
            if (!isC) begin
                regA <= instruction;
            end else if (instruction[5]) begin
                regA <= aluOut;
            end
            if (isC && instruction[4]) begin
                regD <= aluOut;
            end
            pc <= jump ? regA : (pc + 16'h0001);
        end
    end

    assign outM     = aluOut;
    assign writeM   = isC & instruction[3] & ~hold;
    assign addressM = regA[14:0];
endmodule

module HackMemory (
    input  logic        clk,
    input  logic [14:0] address,
    input  logic [15:0] inData,
    input  logic        write,
    output logic [15:0] outData
);
    logic [15:0] ram [16384];

    // Only the 16K data RAM is backed; screen and keyboard space read as zero
    always_ff @(posedge clk) begin
        if (write && !address[14]) begin
            ram[address[13:0]] <= inData;
        end
    end

    assign outData = address[14] ? 16'h0000 : ram[address[13:0]];
endmodule

module hack_boot_system #(
    parameter int IMEM_AW    = 10,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_valid,
    input  logic [15:0]        prog_data,
    input  logic               prog_last,
    output logic               prog_ready,
    output logic [1:0]         state,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [IMEM_AW:0]   prog_len,
    output logic [15:0]        pc_out
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } bootState_t;

    bootState_t         curState;
    bootState_t         nextState;
    logic [IMEM_AW-1:0] loadAddr;
    logic [15:0]        imem [2**IMEM_AW];
    logic [15:0]        pc;
    logic [15:0]        pcD1;
    logic [15:0]        pcD2;
    logic [15:0]        instruction;
    logic [15:0]        cpuOutM;
    logic [15:0]        memOut;
    logic [14:0]        cpuAddressM;
    logic               cpuWriteM;
    logic               cpuHold;
    logic               accept;
    logic               lastAddr;
    logic               haltDetect;
    logic               hitLimit;
    logic               pcInRange;
    logic               sessionStart;

    assign sessionStart = start && ((curState == IDLE) || (curState == HALT));
    assign accept       = prog_valid && prog_ready;
    assign lastAddr     = (loadAddr == {IMEM_AW{1'b1}});

    // A two-instruction self-loop shows up as pc repeating with period two
    assign haltDetect = (curState == RUN) && (cycle_count >= CNT_W'(2)) &&
                        (pc == pcD2) && (pc != pcD1);
    assign hitLimit   = (curState == RUN) && (cycle_count == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE, HALT: begin
                if (start) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                if (accept && (prog_last || lastAddr)) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (haltDetect || hitLimit) begin
                    nextState = HALT;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        prog_ready = 1'b0;
        cpuHold    = 1'b1;
        case (curState)
            LOAD:    prog_ready = 1'b1;
            RUN:     cpuHold    = 1'b0;
            default: ;
        endcase
    end

    // Session bookkeeping; done wins over timeout when both fire together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadAddr    <= '0;
            prog_len    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            pcD1        <= 16'h0000;
            pcD2        <= 16'h0000;
        end else if (sessionStart) begin
            loadAddr    <= '0;
            prog_len    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            pcD1        <= 16'h0000;
            pcD2        <= 16'h0000;
        end else if (curState == LOAD) begin
            if (accept) begin
                loadAddr <= loadAddr + 1'b1;
                prog_len <= prog_len + 1'b1;
            end
        end else if (curState == RUN) begin
            cycle_count <= cycle_count + 1'b1;
            pcD1        <= pc;
            pcD2        <= pcD1;
            if (haltDetect) begin
                done <= 1'b1;
            end else if (hitLimit) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((curState == LOAD) && accept) begin
            imem[loadAddr] <= prog_data;
        end
    end

    // Anything beyond the loaded program fetches as @0 so stale words never run
    assign pcInRange   = (pc[15:IMEM_AW] == '0) && ({1'b0, pc[IMEM_AW-1:0]} < prog_len);
    assign instruction = pcInRange ? imem[pc[IMEM_AW-1:0]] : 16'h0000;

    HackCpu cpu (
        .clk         (clk),
        .rst         (rst),
        .hold        (cpuHold),
        .instruction (instruction),
        .inM         (memOut),
        .outM        (cpuOutM),
        .writeM      (cpuWriteM),
        .addressM    (cpuAddressM),
        .pc          (pc)
    );

    HackMemory dataMem (
        .clk     (clk),
        .address (cpuAddressM),
        .inData  (cpuOutM),
        .write   (cpuWriteM),
        .outData (memOut)
    );

    assign state  = curState;
    assign pc_out = pc;
endmodule

// File: tb/tb_hack_boot_system.sv
// Randomized self-checking bench for hack_boot_system against an instruction-level
// Hack interpreter that applies the loader, fetch-masking and halt/timeout rules.

module tb_hack_boot_system;
    localparam int IMEM_AW    = 3;
    localparam int CNT_W      = 32;
    localparam int MAX_CYCLES = 50;
    localparam int DEPTH      = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              prog_valid;
    logic [15:0]       prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic [1:0]        state;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [IMEM_AW:0]  prog_len;
    logic [15:0]       pc_out;

    int checks   = 0;
    int failures = 0;

    logic [15:0] progWords [16];
    logic        progLast  [16];
    int          nWords;
    int          expLen;
    int          expCycles;
    bit          expDone;
    bit          expTimeout;
    logic [15:0] mA;
    logic [15:0] mD;
    logic [15:0] mMem [16384];
    logic [5:0]  compTable [18];

    hack_boot_system #(
        .IMEM_AW    (IMEM_AW),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_valid  (prog_valid),
        .prog_data   (prog_data),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .state       (state),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .prog_len    (prog_len),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] aluRef(input logic [5:0] comp, input logic [15:0] d, input logic [15:0] y);
        case (comp)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return 16'(0 - d);
            6'b110011: return 16'(0 - y);
            6'b011111: return 16'(d + 1);
            6'b110111: return 16'(y + 1);
            6'b001110: return 16'(d - 1);
            6'b110010: return 16'(y - 1);
            6'b000010: return 16'(d + y);
            6'b010011: return 16'(d - y);
            6'b000111: return 16'(y - d);
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'hDEAD;
        endcase
    endfunction

    function automatic logic [15:0] memRead(input logic [15:0] addr);
        if (addr[14]) return 16'h0000;
        return mMem[addr[13:0]];
    endfunction

    // Reference: loaded length, then one instruction per cycle until loop or limit
    task automatic modelSession();
        int pcTrace [$];
        int pc;
        expLen = 0;
        for (int i = 0; i < nWords; i++) begin
            expLen++;
            if (progLast[i] || expLen == DEPTH) break;
        end
        pc = 0;
        expDone = 0;
        expTimeout = 0;
        expCycles = 0;
        for (int c = 0; c < MAX_CYCLES; c++) begin
            logic [15:0] instr;
            logic [15:0] y;
            logic [15:0] res;
            logic [15:0] oldA;
            bit detect;
            bit jmp;
            int nextPc;
            pcTrace.push_back(pc);
            detect = (c >= 2) && (pcTrace[c] == pcTrace[c-2]) && (pcTrace[c] != pcTrace[c-1]);
            instr = (pc < expLen) ? progWords[pc] : 16'h0000;
            oldA = mA;
            if (!instr[15]) begin
                mA = instr;
                nextPc = pc + 1;
            end else begin
                y = instr[12] ? memRead(oldA) : oldA;
                res = aluRef(instr[11:6], mD, y);
                jmp = (instr[2] && $signed(res) < 0) || (instr[1] && res == 16'h0000) ||
                      (instr[0] && $signed(res) > 0);
                nextPc = jmp ? int'(oldA) : pc + 1;
                if (instr[3] && !oldA[14]) mMem[oldA[13:0]] = res;
                if (instr[4]) mD = res;
                if (instr[5]) mA = res;
            end
            pc = nextPc & 32'hFFFF;
            if (detect) begin
                expDone = 1;
                expCycles = c + 1;
                break;
            end
            if (c == MAX_CYCLES - 1) begin
                expTimeout = 1;
                expCycles = MAX_CYCLES;
            end
        end
    endtask

    task automatic applyStimulus(input int gapPct);
        int idx;
        int guard;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("loadState", 32'(state), 32'd1);
        checkOutput("loadReady", 32'(prog_ready), 32'd1);
        checkOutput("clearCount", 32'(cycle_count), 32'd0);
        checkOutput("clearLen", 32'(prog_len), 32'd0);
        checkOutput("clearFlags", 32'({done, timeout}), 32'd0);
        idx = 0;
        guard = 0;
        while (idx < nWords && prog_ready && guard < 200) begin
            guard++;
            if (int'($urandom_range(0, 99)) < gapPct) begin
                prog_valid = 1'b0;
                prog_data  = 16'($urandom);
                prog_last  = 1'($urandom);
            end else begin
                prog_valid = 1'b1;
                prog_data  = progWords[idx];
                prog_last  = progLast[idx];
            end
            @(negedge clk);
            if (prog_valid) idx++;
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        checkOutput("acceptCount", 32'(idx), 32'(expLen));
        checkOutput("lenLoaded", 32'(prog_len), 32'(expLen));
        checkOutput("runEntry", 32'(state), 32'd2);
        checkOutput("readyDrop", 32'(prog_ready), 32'd0);
        checkOutput("pcFirst", 32'(pc_out), 32'd0);
    endtask

    task automatic finishRun();
        int guard;
        guard = 0;
        while (state != 2'd3 && guard < MAX_CYCLES + 20) begin
            prog_valid = 1'($urandom);
            prog_data  = 16'($urandom);
            start      = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        prog_valid = 1'b0;
        start      = 1'b0;
        checkOutput("haltReached", 32'(state), 32'd3);
        checkOutput("doneFlag", 32'(done), 32'(expDone));
        checkOutput("timeoutFlag", 32'(timeout), 32'(expTimeout));
        checkOutput("cycleCount", 32'(cycle_count), 32'(expCycles));
        checkOutput("lenAfterRun", 32'(prog_len), 32'(expLen));
        repeat (2) @(negedge clk);
        checkOutput("countFrozen", 32'(cycle_count), 32'(expCycles));
        checkOutput("pcHeld", 32'(pc_out), 32'd0);
        checkOutput("doneHeld", 32'(done), 32'(expDone));
    endtask

    function automatic logic [15:0] randomInstr();
        logic [2:0] destSel [4];
        destSel[0] = 3'b000;
        destSel[1] = 3'b010;
        destSel[2] = 3'b001;
        destSel[3] = 3'b011;
        if ($urandom_range(0, 99) < 35) return 16'($urandom_range(0, 3));
        return {3'b111, 1'($urandom), compTable[$urandom_range(0, 17)],
                destSel[$urandom_range(0, 3)],
                ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compTable = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                      6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                      6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
        for (int i = 0; i < 16384; i++) mMem[i] = 16'h0000;
        mA = 16'h0000;
        mD = 16'h0000;
        rst = 1'b1;
        start = 1'b0;
        prog_valid = 1'b0;
        prog_data = 16'h0000;
        prog_last = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstState", 32'(state), 32'd0);
        checkOutput("rstOutputs", 32'({prog_ready, done, timeout}), 32'd0);
        checkOutput("rstCount", 32'(cycle_count), 32'd0);
        checkOutput("rstPc", 32'(pc_out), 32'd0);
        rst = 1'b0;
        prog_valid = 1'b1;
        prog_data = 16'h1234;
        repeat (2) @(negedge clk);
        prog_valid = 1'b0;
        checkOutput("idleIgnoresValid", 32'({state, prog_ready, prog_len}), 32'd0);

        // Loop program ending in @2 / 0;JMP at addresses 2 and 3
        nWords = 4;
        progWords[0] = 16'h0000; progWords[1] = 16'h0000;
        progWords[2] = 16'h0002; progWords[3] = 16'hEA87;
        for (int i = 0; i < 4; i++) progLast[i] = (i == 3);
        modelSession();
        applyStimulus(0);
        finishRun();

        // @7; D=A; @0; M=D; then loop at 4/5
        nWords = 6;
        progWords[0] = 16'h0007; progWords[1] = 16'hEC10; progWords[2] = 16'h0000;
        progWords[3] = 16'hE308; progWords[4] = 16'h0004; progWords[5] = 16'hEA87;
        for (int i = 0; i < 6; i++) progLast[i] = (i == 5);
        modelSession();
        applyStimulus(30);
        finishRun();
        checkOutput("mem0Seven", 32'(dut.dataMem.ram[0]), 32'(mMem[0]));

        // Straight-line @0 words only, runs off the end into timeout
        nWords = 5;
        for (int i = 0; i < 5; i++) begin
            progWords[i] = 16'h0000;
            progLast[i] = (i == 4);
        end
        modelSession();
        applyStimulus(20);
        finishRun();

        // Zero data RAM 0..3 so later random programs read defined values
        nWords = 8;
        for (int i = 0; i < 8; i++) begin
            progWords[i] = (i % 2 == 0) ? 16'(i / 2) : 16'hEA88;
            progLast[i] = (i == 7);
        end
        modelSession();
        applyStimulus(0);
        finishRun();
        for (int i = 0; i < 4; i++) checkOutput("memInit", 32'(dut.dataMem.ram[i]), 32'(mMem[i]));

        // Overflow: ten words without prog_last into an 8-word RAM
        nWords = 10;
        for (int i = 0; i < 10; i++) begin
            progWords[i] = 16'h0000;
            progLast[i] = 1'b0;
        end
        modelSession();
        applyStimulus(25);
        finishRun();

        // Reset in the middle of a run, then a 1-word program over stale words
        nWords = 4;
        progWords[0] = 16'h0000; progWords[1] = 16'h0000;
        progWords[2] = 16'h0002; progWords[3] = 16'hEA87;
        for (int i = 0; i < 4; i++) progLast[i] = (i == 3);
        modelSession();
        applyStimulus(0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstState", 32'(state), 32'd0);
        checkOutput("midRstOutputs", 32'({prog_ready, done, timeout}), 32'd0);
        checkOutput("midRstCount", 32'(cycle_count), 32'd0);
        checkOutput("midRstLen", 32'(prog_len), 32'd0);
        checkOutput("midRstPc", 32'(pc_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mA = 16'h0000;
        mD = 16'h0000;
        nWords = 1;
        progWords[0] = 16'h0000;
        progLast[0] = 1'b1;
        modelSession();
        applyStimulus(0);
        finishRun();

        for (int s = 0; s < 20; s++) begin
            nWords = ($urandom_range(0, 4) == 0) ? 10 : int'($urandom_range(1, 8));
            for (int i = 0; i < nWords; i++) begin
                progWords[i] = randomInstr();
                progLast[i] = (nWords <= DEPTH) && (i == nWords - 1);
            end
            modelSession();
            applyStimulus(30);
            finishRun();
            for (int i = 0; i < 4; i++) checkOutput("memRandom", 32'(dut.dataMem.ram[i]), 32'(mMem[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
